// File: rtl/config_frame_sequencer.sv
// rtl/config_frame_sequencer.sv - configuration word stream to fabric row-write sequencer
module config_frame_sequencer #(
    parameter int          NumberOfRows    = 14,
    parameter int          RowSelectWidth  = 5,
    parameter int          FrameBitsPerRow = 32,
    parameter int          desync_flag     = 20,
    parameter int          TimeoutCycles   = 1024,
    parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [31:0]                ConfigWriteData,
    input  logic                       ConfigWriteStrobe,
    output logic [FrameBitsPerRow-1:0] FrameAddressRegister,
    output logic                       LongFrameStrobe,
    output logic [RowSelectWidth-1:0]  RowSelect,
    output logic [7:0]                 FrameSelect,
    output logic                       Active,
    output logic                       FrameDone
);

    localparam int IdleWidth = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {IDLE, HEADER, LOAD} state_t;

    state_t                    state, state_next;
    logic [RowSelectWidth-1:0] row_cnt, row_cnt_next;
    logic [IdleWidth-1:0]      idle_cnt, idle_cnt_next;
    logic [7:0]                frame_sel_next;
    logic                      data_accept;
    logic                      last_row;
    logic                      timeout;

    assign last_row = (row_cnt == RowSelectWidth'(NumberOfRows - 1));
    assign timeout  = (idle_cnt == IdleWidth'(TimeoutCycles - 1));

    always_comb begin
        state_next     = state;
        row_cnt_next   = row_cnt;
        idle_cnt_next  = idle_cnt;
        frame_sel_next = FrameSelect;
        data_accept    = 1'b0;
        if (ConfigWriteStrobe) begin
            // A strobe always restarts the idle window, so it wins over a coincident timeout.
            idle_cnt_next = '0;
            case (state)
                IDLE: begin
                    if (ConfigWriteData == SyncWord) state_next = HEADER;
                end
                HEADER: begin
                    if (ConfigWriteData[desync_flag]) begin
                        state_next = IDLE;
                    end else if (ConfigWriteData != SyncWord) begin
                        frame_sel_next = ConfigWriteData[7:0];
                        row_cnt_next   = '0;
                        state_next     = LOAD;
                    end
                end
                LOAD: begin
                    data_accept = 1'b1;
                    if (last_row) begin
                        row_cnt_next = '0;
                        state_next   = HEADER;
                    end else begin
                        row_cnt_next = row_cnt + RowSelectWidth'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE) begin
            if (timeout) begin
                state_next    = IDLE;
                row_cnt_next  = '0;
                idle_cnt_next = '0;
            end else begin
                idle_cnt_next = idle_cnt + IdleWidth'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state                <= IDLE;
            row_cnt              <= '0;
            idle_cnt             <= '0;
            FrameAddressRegister <= '0;
            RowSelect            <= '0;
            FrameSelect          <= '0;
            LongFrameStrobe      <= 1'b0;
            FrameDone            <= 1'b0;
            Active               <= 1'b0;
        end else begin
            state           <= state_next;
            row_cnt         <= row_cnt_next;
            idle_cnt        <= idle_cnt_next;
            FrameSelect     <= frame_sel_next;
            LongFrameStrobe <= data_accept;
            FrameDone       <= data_accept & last_row;
            Active          <= (state != IDLE);
            if (data_accept) begin
                FrameAddressRegister <= ConfigWriteData[FrameBitsPerRow-1:0];
                RowSelect            <= row_cnt;
            end
        end
    end

endmodule

// File: tb/tb_config_frame_sequencer.sv
// tb/tb_config_frame_sequencer.sv - randomized and directed bench with transaction-level frame model
module tb_config_frame_sequencer;

    localparam int          NR   = 14;
    localparam int          RSW  = 5;
    localparam int          FBR  = 32;
    localparam int          DF   = 20;
    localparam int          TO   = 1024;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    logic           CLK = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    ConfigWriteData = '0;
    logic           ConfigWriteStrobe = 1'b0;
    logic [FBR-1:0] FrameAddressRegister;
    logic           LongFrameStrobe;
    logic [RSW-1:0] RowSelect;
    logic [7:0]     FrameSelect;
    logic           Active;
    logic           FrameDone;

    config_frame_sequencer #(
        .NumberOfRows(NR), .RowSelectWidth(RSW), .FrameBitsPerRow(FBR),
        .desync_flag(DF), .TimeoutCycles(TO), .SyncWord(SYNC)
    ) dut (
        .CLK(CLK), .reset(reset),
        .ConfigWriteData(ConfigWriteData), .ConfigWriteStrobe(ConfigWriteStrobe),
        .FrameAddressRegister(FrameAddressRegister), .LongFrameStrobe(LongFrameStrobe),
        .RowSelect(RowSelect), .FrameSelect(FrameSelect),
        .Active(Active), .FrameDone(FrameDone)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0]    data;
        logic [RSW-1:0] row;
        logic           done;
    } strobe_t;

    strobe_t exp_q[$];
    strobe_t got_q[$];
    int chk = 0;
    int pass = 0;
    int cyc = 0;
    int last_send = 0;
    int hold_err = 0;
    int stray_done = 0;
    logic [FBR-1:0] prev_far = '0;
    logic [RSW-1:0] prev_row = '0;

    // Reference model: 0 = unsynchronised, 1 = expecting header, 2 = collecting rows
    int       m_mode = 0;
    int       m_row = 0;
    logic [7:0] m_fsel = '0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (LongFrameStrobe === 1'b1) got_q.push_back({FrameAddressRegister, RowSelect, FrameDone});
        if (FrameDone === 1'b1 && LongFrameStrobe !== 1'b1) stray_done++;
        if (reset) begin
            prev_far = '0;
            prev_row = '0;
        end else begin
            if (LongFrameStrobe !== 1'b1 && (FrameAddressRegister !== prev_far || RowSelect !== prev_row))
                hold_err++;
            prev_far = FrameAddressRegister;
            prev_row = RowSelect;
        end
    end

    task automatic model_word(input logic [31:0] w, input int gap);
        strobe_t e;
        if (m_mode != 0 && gap >= TO) begin
            m_mode = 0;
            m_row  = 0;
        end
        if (m_mode == 0) begin
            if (w == SYNC) m_mode = 1;
        end else if (m_mode == 1) begin
            if (w[DF]) m_mode = 0;
            else if (w != SYNC) begin
                m_fsel = w[7:0];
                m_row  = 0;
                m_mode = 2;
            end
        end else begin
            e.data = w;
            e.row  = RSW'(m_row);
            e.done = (m_row == NR - 1);
            exp_q.push_back(e);
            m_row++;
            if (m_row == NR) begin
                m_row  = 0;
                m_mode = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK) #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        model_word(w, cyc - last_send - 1);
        last_send = cyc;
        ConfigWriteData   = w;
        ConfigWriteStrobe = 1'b1;
        @(posedge CLK) #1;
        ConfigWriteStrobe = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_row  = 0;
        m_fsel = '0;
        last_send = cyc;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ConfigWriteStrobe = 1'b0;
        idle(2);
        reset = 1'b0;
        model_reset();
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] fsel, input logic [31:0] base);
        send_word(SYNC);
        send_word({24'h0, fsel});
        for (int i = 0; i < NR; i++) send_word(base + 32'(i));
    endtask

    task automatic check_frames(input string name);
        int n;
        idle(2);
        chk++;
        if (got_q.size() != exp_q.size())
            $display("FAIL %s strobe_count got %0d want %0d", name, got_q.size(), exp_q.size());
        else pass++;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk++;
            if (got_q[i] !== exp_q[i])
                $display("FAIL %s strobe[%0d] got data=%h row=%0d done=%b want data=%h row=%0d done=%b",
                         name, i, got_q[i].data, got_q[i].row, got_q[i].done,
                         exp_q[i].data, exp_q[i].row, exp_q[i].done);
            else pass++;
        end
        chk++;
        if (hold_err != 0 || stray_done != 0)
            $display("FAIL %s hold/stray got hold_err=%0d stray_done=%0d want 0 0", name, hold_err, stray_done);
        else pass++;
        hold_err = 0;
        stray_done = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_active(input string name, input logic want);
        chk++;
        if (Active !== want) $display("FAIL %s Active got %b want %b", name, Active, want);
        else pass++;
    endtask

    task automatic check_fsel(input string name);
        chk++;
        if (FrameSelect !== m_fsel) $display("FAIL %s FrameSelect got %h want %h", name, FrameSelect, m_fsel);
        else pass++;
    endtask

    task automatic check_reset_outputs(input string name);
        chk++;
        if ({FrameAddressRegister, LongFrameStrobe, RowSelect, FrameSelect, Active, FrameDone} !== '0)
            $display("FAIL %s outputs got far=%h lfs=%b row=%0d fsel=%h act=%b done=%b want all 0",
                     name, FrameAddressRegister, LongFrameStrobe, RowSelect, FrameSelect, Active, FrameDone);
        else pass++;
    endtask

    task automatic test_reset();
        do_reset();
        check_reset_outputs("reset");
        hold_err = 0;
        stray_done = 0;
    endtask

    task automatic test_basic_frame();
        do_reset();
        send_frame(8'h03, 32'h100);
        check_frames("basic_frame");
        check_fsel("basic_frame");
        check_active("basic_frame_header", 1'b1);
        send_word(32'h0000_0042);
        send_word(32'hDEAD_0001);
        check_frames("basic_next_header");
        check_fsel("basic_next_header");
    endtask

    task automatic test_idle_ignore();
        do_reset();
        send_word(32'h1234_5678);
        idle(1);
        check_active("ignore_nonsync", 1'b0);
        send_word(SYNC);
        check_active("sync_plus1", 1'b0);
        idle(1);
        check_active("sync_plus2", 1'b1);
        check_frames("idle_ignore");
    endtask

    task automatic test_desync();
        do_reset();
        send_word(SYNC);
        send_word(32'h0010_0000);
        idle(1);
        check_active("desync", 1'b0);
        for (int i = 0; i < 4; i++) send_word(32'h200 + 32'(i));
        check_frames("desync_no_strobes");
    endtask

    task automatic test_timeout();
        do_reset();
        send_word(SYNC);
        send_word(32'h0000_0007);
        for (int i = 0; i < 5; i++) send_word(32'h300 + 32'(i));
        idle(TO + 4);
        check_active("timeout", 1'b0);
        send_word(32'h0000_0009);
        send_frame(8'h05, 32'h400);
        check_frames("timeout_restart");
        check_fsel("timeout_restart");
    endtask

    task automatic test_timeout_boundary();
        do_reset();
        send_word(SYNC);
        send_word(32'h0000_0011);
        send_word(32'h500);
        idle(TO - 1);
        send_word(32'h501);
        idle(TO);
        send_word(32'h502);
        check_frames("timeout_boundary");
        check_active("timeout_boundary", 1'b0);
    endtask

    task automatic test_sync_as_data();
        do_reset();
        send_word(SYNC);
        send_word(32'h0000_0021);
        send_word(32'h600);
        send_word(32'h601);
        send_word(SYNC);
        send_word(32'h0010_0000);
        for (int i = 4; i < NR; i++) send_word(32'h600 + 32'(i));
        check_frames("sync_as_data");
        check_active("sync_as_data", 1'b1);
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_word(SYNC);
        send_word(32'h0000_0031);
        for (int i = 0; i < 7; i++) send_word(32'h700 + 32'(i));
        ConfigWriteData   = 32'h707;
        ConfigWriteStrobe = 1'b1;
        reset             = 1'b1;
        @(posedge CLK) #1;
        reset             = 1'b0;
        ConfigWriteStrobe = 1'b0;
        model_reset();
        check_reset_outputs("reset_mid_load");
        for (int i = 8; i < 11; i++) send_word(32'h700 + 32'(i));
        check_frames("reset_mid_load");
    endtask

    task automatic test_random();
        logic [31:0] w;
        int r;
        int gap;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2) w = SYNC;
            else if (r == 2) w = $urandom() | 32'h0010_0000;
            else if (r == 3) w = $urandom() & ~32'h0010_0000;
            else w = $urandom();
            if ($urandom_range(0, 79) == 0) gap = $urandom_range(0, 1) ? TO - 1 : TO;
            else gap = $urandom_range(0, 2);
            idle(gap);
            send_word(w);
        end
        idle(3);
        check_active("random", (m_mode != 0));
        check_fsel("random");
        check_frames("random");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_idle_ignore();
        test_desync();
        test_timeout();
        test_timeout_boundary();
        test_sync_as_data();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

endmodule
